bf16_psum_accumulator: RTL

Downstream stage of the 2-element BF16 dot-product core. Consumes its stream of BF16 partial sums and adds them sequentially into one BF16 result per vector. The accumulator uses an extended internal significand, so one rounding happens at the end instead of one per term. Sits between the dot-product core output and the result write-back.

---
 rtl/bf16_psum_accumulator.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bf16_psum_accumulator.sv
// Sequential BF16 partial-sum accumulator with an extended internal significand and a single final rounding.
// Optional macro BF16_ACC_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module bf16_psum_accumulator #(
  parameter int MANT_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

  state_t              state;
  logic                acc_sign, acc_sticky, acc_nan, last_q;
  logic [7:0]          acc_exp, t_exp;
  logic [MANT_W-1:0]   acc_sig, t_sig, al_a, al_b;
  logic                t_sign, sum_sign;
  logic [MANT_W:0]     sum;
  logic [CNT_W-1:0]    cnt;
  logic                in_ready_q, out_valid_q;
  logic [15:0]         out_data_q;
  logic [CNT_W-1:0]    out_count_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Alignment: the smaller-exponent operand is shifted right, lost bits feed sticky.
  logic              a_big, sh_sticky;
  logic [7:0]        diff;
  logic [MANT_W-1:0] shift_in, shifted;
  always_comb begin
    a_big    = (acc_exp >= t_exp);
    diff     = a_big ? (acc_exp - t_exp) : (t_exp - acc_exp);
    shift_in = a_big ? t_sig : acc_sig;
    if (int'(diff) >= MANT_W) begin
      shifted   = '0;
      sh_sticky = |shift_in;
    end else begin
      shifted   = shift_in >> diff;
      sh_sticky = |(shift_in << (MANT_W - int'(diff)));
    end
  end

  logic [MANT_W:0] add_res;
  logic            add_sign;
  always_comb begin
    if (acc_sign == t_sign) begin
      add_res  = {1'b0, al_a} + {1'b0, al_b};
      add_sign = acc_sign;
    end else if (al_a >= al_b) begin
      add_res  = {1'b0, al_a} - {1'b0, al_b};
      add_sign = acc_sign;
    end else begin
      add_res  = {1'b0, al_b} - {1'b0, al_a};
      add_sign = t_sign;
    end
    if (add_res == '0) add_sign = 1'b0;
  end

  int                lz, norm_exp;
  logic              found, norm_zero, norm_sat, norm_stk;
  logic [MANT_W-1:0] norm_sig;
  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + 1;
      end
    end
    norm_stk = 1'b0;
    if (sum[MANT_W]) begin
      norm_sig = sum[MANT_W:1];
      norm_exp = int'(acc_exp) + 1;
      norm_stk = sum[0];
    end else begin
      norm_sig = sum[MANT_W-1:0] << lz;
      norm_exp = int'(acc_exp) - lz;
    end
    norm_zero = (sum == '0) || (norm_exp <= 0);
    norm_sat  = !norm_zero && (norm_exp >= 255);
  end

  logic [6:0]  frac;
  logic [14:0] ef;
  logic [15:0] rnd_data;
`ifdef BF16_ACC_RNE_EN
  localparam logic [MANT_W-1:0] REST_MASK = {MANT_W{1'b1}} >> 9;
  logic guard, rest, rnd_up;
`endif
  always_comb begin
    frac = acc_sig[MANT_W-2 -: 7];
`ifdef BF16_ACC_RNE_EN
    guard  = acc_sig[MANT_W-9];
    rest   = |(acc_sig & REST_MASK);
    rnd_up = guard & (rest | acc_sticky | frac[0]);
    ef     = {acc_exp, frac} + 15'(rnd_up);
    if (ef[14:7] == 8'hFF) ef = {8'd254, 7'h7F};
`else
    ef = {acc_exp, frac};
`endif
    if (acc_nan)              rnd_data = 16'h7FC0;
    else if (acc_exp == 8'd0) rnd_data = 16'h0000;
    else                      rnd_data = {acc_sign, ef};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_sign    <= 1'b0;
      acc_exp     <= '0;
      acc_sig     <= '0;
      acc_sticky  <= 1'b0;
      acc_nan     <= 1'b0;
      last_q      <= 1'b0;
      t_sign      <= 1'b0;
      t_exp       <= '0;
      t_sig       <= '0;
      al_a        <= '0;
      al_b        <= '0;
      sum         <= '0;
      sum_sign    <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            t_sign <= in_data[15];
            if (in_data[14:7] == 8'd0 || in_data[14:7] == 8'hFF) begin
              t_exp <= '0;
              t_sig <= '0;
            end else begin
              t_exp <= in_data[14:7];
              t_sig <= {1'b1, in_data[6:0], {(MANT_W-8){1'b0}}};
            end
            if (in_data[14:7] == 8'hFF) acc_nan <= 1'b1;
            last_q <= in_last;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            in_ready_q <= 1'b0;
            state      <= ALIGN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ALIGN: begin
          al_a       <= a_big ? acc_sig : shifted;
          al_b       <= a_big ? shifted : t_sig;
          acc_exp    <= a_big ? acc_exp : t_exp;
          acc_sticky <= acc_sticky | sh_sticky;
          state      <= ADD;
        end
        ADD: begin
          sum      <= add_res;
          sum_sign <= add_sign;
          state    <= NORM;
        end
        NORM: begin
          if (norm_zero) begin
            acc_sign <= 1'b0;
            acc_exp  <= '0;
            acc_sig  <= '0;
          end else if (norm_sat) begin
            acc_sign <= sum_sign;
            acc_exp  <= 8'd254;
            acc_sig  <= '1;
          end else begin
            acc_sign <= sum_sign;
            acc_exp  <= norm_exp[7:0];
            acc_sig  <= norm_sig;
          end
          acc_sticky <= acc_sticky | norm_stk;
          if (last_q) begin
            state <= ROUND;
          end else begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        ROUND: begin
          out_data_q  <= rnd_data;
          out_count_q <= cnt;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            acc_sign    <= 1'b0;
            acc_exp     <= '0;
            acc_sig     <= '0;
            acc_sticky  <= 1'b0;
            acc_nan     <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
